// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes (also used by ALUControl), FSM states,
// default datapath width and the iterative-opcode predicate.
// MULTICYCLE_ALU_DIV_EN: when defined, DIVU counts as an iterative op.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    // Codes 0..7 are the legacy single-cycle ALU encodings.
    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NOR   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_LUI   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Ops that run through the shift-add / restoring-divide iterator.
    function automatic logic is_iterative(input logic [3:0] op);
`ifdef MULTICYCLE_ALU_DIV_EN
        return (op == OP_MULTU) || (op == OP_DIVU);
`else
        return (op == OP_MULTU);
`endif
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per step.
// Ports: clk, reset (async, active-high); load latches operands and
//   sets cnt=WIDTH-1; step advances one bit; is_div selects DIVU at load;
//   a/b operands; cnt_zero flags last step; hi_next/lo_next are the
//   values after the current step; div_by_zero flags a latched DIVU by 0.
// MULTICYCLE_ALU_DIV_EN: when undefined the divide path is not built.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cnt_zero,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    // hi/lo: product {hi,lo} for MULTU, {remainder,quotient/dividend}
    // for DIVU. m holds the multiplicand or divisor.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   mul_sum;

`ifdef MULTICYCLE_ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
`else
    logic             div_unused;
    assign div_unused = is_div;
`endif

    assign cnt_zero = (cnt_q == '0);

    // Next-step datapath.
    always_comb begin
        // Multiply: add m when the low multiplier bit is set, then
        // shift the {carry,hi,lo} triple right by one.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        hi_next = mul_sum[WIDTH:1];
        lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIV_EN
        // Divide: shift next dividend bit into the remainder and
        // keep the trial subtraction if it did not borrow. With m=0
        // this yields all-ones quotient and remainder = dividend.
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, m_q};
        if (div_q) begin
            if (!rem_diff[WIDTH]) begin
                hi_next = rem_diff[WIDTH-1:0];
                lo_next = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = rem_sh[WIDTH-1:0];
                lo_next = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        m_d   = m_q;
`ifdef MULTICYCLE_ALU_DIV_EN
        div_d = div_q;
`endif
        if (load) begin
            cnt_d = CNT_W'(WIDTH - 1);
            hi_d  = '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_d = is_div;
            lo_d  = is_div ? a : b;
            m_d   = is_div ? b : a;
`else
            lo_d  = b;
            m_d   = a;
`endif
        end else if (step) begin
            hi_d = hi_next;
            lo_d = lo_next;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_q <= div_d;
`endif
        end
    end

`ifdef MULTICYCLE_ALU_DIV_EN
    assign div_by_zero = div_q && (m_q == '0);
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: rtl/multicycle_alu.sv
// EX-stage ALU with start/done handshake; MULTU/DIVU iterate WIDTH steps.
// Ports: clk, reset (async, active-high), start, ALUOperation, A, B,
//   shamt in; busy, done, ALUResult, HiResult, Zero, DivByZero out.
// MULTICYCLE_ALU_DIV_EN: define to build DIVU; otherwise opcode 11
//   behaves as an undefined single-cycle op returning 0.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   ALUResult,
    output logic [WIDTH-1:0]   HiResult,
    output logic               Zero,
    output logic               DivByZero
);

    localparam int LUI_W = (WIDTH < 16) ? WIDTH : 16;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic [WIDTH-1:0] hi_result_q, hi_result_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic             md_load;
    logic             md_step;
    logic             md_cnt_zero;
    logic             md_dbz;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic             is_div_in;

    logic [WIDTH-1:0]  single_res;
    logic [WIDTH+15:0] lui_wide;

    assign is_div_in = (ALUOperation == OP_DIVU);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk         (clk),
        .reset       (reset),
        .load        (md_load),
        .step        (md_step),
        .is_div      (is_div_in),
        .a           (A),
        .b           (B),
        .cnt_zero    (md_cnt_zero),
        .hi_next     (md_hi),
        .lo_next     (md_lo),
        .div_by_zero (md_dbz)
    );

    // Single-cycle ops act on the live inputs; they are captured on
    // the accepting edge, so later input changes cannot leak through.
    always_comb begin
        lui_wide = '0;
        lui_wide[LUI_W+15:16] = B[LUI_W-1:0];
        single_res = '0;
        case (ALUOperation)
            OP_AND: single_res = A & B;
            OP_OR:  single_res = A | B;
            OP_NOR: single_res = ~(A | B);
            OP_ADD: single_res = A + B;
            OP_SUB: single_res = A - B;
            OP_LUI: single_res = lui_wide[WIDTH-1:0];
            OP_SLL: single_res = B << shamt;
            OP_SRL: single_res = B >> shamt;
            OP_SRA: single_res = $signed(B) >>> shamt;
            OP_SLT: single_res[0] = $signed(A) < $signed(B);
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        md_load      = 1'b0;
        md_step      = 1'b0;
        alu_result_d = alu_result_q;
        hi_result_d  = hi_result_q;
        zero_d       = zero_q;
        dbz_d        = dbz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_iterative(ALUOperation)) begin
                        md_load = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        alu_result_d = single_res;
                        hi_result_d  = '0;
                        zero_d       = (single_res == '0);
                        dbz_d        = 1'b0;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                md_step = 1'b1;
                // Final step: register the stepped values directly.
                if (md_cnt_zero) begin
                    alu_result_d = md_lo;
                    hi_result_d  = md_hi;
                    zero_d       = (md_lo == '0);
                    dbz_d        = md_dbz;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            alu_result_q <= '0;
            hi_result_q  <= '0;
            zero_q       <= 1'b0;
            dbz_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_result_q <= alu_result_d;
            hi_result_q  <= hi_result_d;
            zero_q       <= zero_d;
            dbz_q        <= dbz_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign ALUResult = alu_result_q;
    assign HiResult  = hi_result_q;
    assign Zero      = zero_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: directed spec cases plus randomized ops
// against a behavioural reference model.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        busy, done, zero, dbz;
    logic [31:0] res, hi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_alu dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (op),
        .A            (a),
        .B            (b),
        .shamt        (sh),
        .busy         (busy),
        .done         (done),
        .ALUResult    (res),
        .HiResult     (hi),
        .Zero         (zero),
        .DivByZero    (dbz)
    );

    // Reference: result/hi/divbyzero/latency from the opcode rules.
    function automatic void ref_model(
        input  logic [3:0]  o,
        input  logic [31:0] x,
        input  logic [31:0] y,
        input  logic [4:0]  s,
        output logic [31:0] r,
        output logic [31:0] h,
        output logic        dz,
        output int          lat
    );
        logic [63:0] p;
        r = 0; h = 0; dz = 0; lat = 1;
        case (o)
            4'd0: r = x & y;
            4'd1: r = x | y;
            4'd2: r = ~(x | y);
            4'd3: r = x + y;
            4'd4: r = x - y;
            4'd5: r = {y[15:0], 16'h0000};
            4'd6: r = y << s;
            4'd7: r = y >> s;
            4'd8: r = $signed(y) >>> s;
            4'd9: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd10: begin
                p = 64'(x) * 64'(y);
                r = p[31:0];
                h = p[63:32];
                lat = 33;
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            4'd11: begin
                lat = 33;
                if (y == 0) begin
                    r = 32'hFFFF_FFFF; h = x; dz = 1;
                end else begin
                    r = x / y; h = x % y;
                end
            end
`endif
            default: r = 0;
        endcase
    endfunction

    // Stimulus only: wait idle, launch one op, scramble inputs while
    // it runs, optionally pulse start at cycle poke_at, wait for done.
    task automatic launch(
        input  logic [3:0]  o,
        input  logic [31:0] xa,
        input  logic [31:0] xb,
        input  logic [4:0]  xs,
        input  int          poke_at,
        output int          lat
    );
        int g = 0;
        while (busy !== 1'b0 && g < 100) begin
            @(posedge clk); #1; g++;
        end
        @(negedge clk);
        op = o; a = xa; b = xb; sh = xs; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            op = 4'($urandom); a = $urandom; b = $urandom;
            sh = 5'($urandom);
            start = (lat == poke_at);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 0; a = 0; b = 0; sh = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, res, hi, zero, dbz} !== 68'd0) begin
            errors++;
            $display("FAIL reset_state got %h want 0",
                     {busy, done, res, hi, zero, dbz});
        end
        reset = 1'b0;
    endtask

    task automatic test_single_cycle();
        logic [3:0]  t_op [11];
        logic [31:0] t_a [11], t_b [11], t_r [11];
        logic [4:0]  t_s [11];
        int lat;
        t_op = '{4'd3, 4'd9, 4'd8, 4'd5, 4'd5, 4'd4,
                 4'd2, 4'd6, 4'd7, 4'd9, 4'd15};
        t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0, 0,
                 0, 0, 0, 1, 32'hFFFF_FFFF};
        t_b  = '{1, 0, 32'h8000_0000, 32'h0000_1234, 32'hABCD_1234, 1,
                 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_s  = '{0, 0, 4, 0, 0, 0, 0, 31, 31, 0, 0};
        t_r  = '{0, 1, 32'hF800_0000, 32'h1234_0000, 32'h1234_0000,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0};
        for (int i = 0; i < 11; i++) begin
            launch(t_op[i], t_a[i], t_b[i], t_s[i], -1, lat);
            checks++;
            if ({8'(lat), res, hi, zero, dbz} !==
                {8'd1, t_r[i], 32'd0, t_r[i] == 0, 1'b0}) begin
                errors++;
                $display("FAIL single_%0d got lat=%0d r=%h h=%h z=%b d=%b want lat=1 r=%h",
                         i, lat, res, hi, zero, dbz, t_r[i]);
            end
        end
    endtask

    task automatic test_multu();
        int lat;
        launch(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 10, lat);
        checks++;
        if ({8'(lat), hi, res, zero} !==
            {8'd33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0}) begin
            errors++;
            $display("FAIL multu_max got lat=%0d h=%h r=%h z=%b want 33 fffffffe 00000001",
                     lat, hi, res, zero);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL multu_poke_ignored got busy=%b done=%b want 0 0",
                     busy, done);
        end
        launch(4'd10, 0, 32'h1234_5678, 0, -1, lat);
        checks++;
        if ({8'(lat), hi, res, zero} !== {8'd33, 64'd0, 1'b1}) begin
            errors++;
            $display("FAIL multu_zero got lat=%0d h=%h r=%h z=%b want 33 0 0 1",
                     lat, hi, res, zero);
        end
    endtask

    task automatic test_divu();
        int lat;
        launch(4'd11, 100, 7, 0, -1, lat);
        checks++;
`ifdef MULTICYCLE_ALU_DIV_EN
        if ({8'(lat), res, hi, dbz} !== {8'd33, 32'd14, 32'd2, 1'b0}) begin
`else
        if ({8'(lat), res, hi, dbz} !== {8'd1, 32'd0, 32'd0, 1'b0}) begin
`endif
            errors++;
            $display("FAIL divu_100_7 got lat=%0d r=%h h=%h dz=%b",
                     lat, res, hi, dbz);
        end
        launch(4'd11, 5, 0, 0, -1, lat);
        checks++;
`ifdef MULTICYCLE_ALU_DIV_EN
        if ({8'(lat), res, hi, dbz} !==
            {8'd33, 32'hFFFF_FFFF, 32'd5, 1'b1}) begin
`else
        if ({8'(lat), res, hi, dbz} !== {8'd1, 32'd0, 32'd0, 1'b0}) begin
`endif
            errors++;
            $display("FAIL divu_by_zero got lat=%0d r=%h h=%h dz=%b",
                     lat, res, hi, dbz);
        end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] x, y, er, eh;
        logic [4:0]  s;
        logic        ed;
        int          el, lat;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            if (i % 5 == 0) o = (i % 10 == 0) ? 4'd10 : 4'd11;
            x = $urandom; y = $urandom; s = 5'($urandom);
            if (i % 7 == 0) y = 0;
            if (i % 3 == 0) y = y >> 20;
            ref_model(o, x, y, s, er, eh, ed, el);
            launch(o, x, y, s, (i % 4 == 0) ? 5 : -1, lat);
            checks++;
            if ({8'(lat), res, hi, zero, dbz} !==
                {8'(el), er, eh, er == 0, ed}) begin
                errors++;
                $display("FAIL random_%0d op=%0d got lat=%0d r=%h h=%h z=%b d=%b want lat=%0d r=%h h=%h d=%b",
                         i, o, lat, res, hi, zero, dbz, el, er, eh, ed);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, seen;
        launch(4'd3, 5, 6, 0, -1, lat);
        @(posedge clk); #1;
        @(negedge clk);
        op = 4'd10; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, res, hi, zero, dbz} !== 68'd0) begin
            errors++;
            $display("FAIL reset_mid_multu got %h want 0",
                     {busy, done, res, hi, zero, dbz});
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_discard got %0d done pulses want 0", seen);
        end
        launch(4'd3, 32'h10, 32'h20, 0, -1, lat);
        checks++;
        if ({8'(lat), res, zero} !== {8'd1, 32'h30, 1'b0}) begin
            errors++;
            $display("FAIL add_after_reset got lat=%0d r=%h want 1 30",
                     lat, res);
        end
    endtask

    task automatic test_back_to_back(input logic [3:0] o, input int nacc);
        logic [31:0] sa, sb, er, eh, lr, lh;
        logic [4:0]  ss;
        logic        ed, ld, have;
        int          el, j, g;
        ref_model(o, 0, 1, 0, er, eh, ed, el);
        g = 0;
        while (busy !== 1'b0 && g < 100) begin
            @(posedge clk); #1; g++;
        end
        have = 0; sa = 0; sb = 0; ss = 0;
        lr = 0; lh = 0; ld = 0;
        for (int k = 0; k < nacc * (el + 1); k++) begin
            j = k % (el + 1);
            @(negedge clk);
            op = o; a = $urandom; b = $urandom; sh = 5'($urandom);
            start = 1'b1;
            if (j == 0) begin
                sa = a; sb = b; ss = sh;
            end
            @(posedge clk); #1;
            checks++;
            if (done !== (j == el - 1)) begin
                errors++;
                $display("FAIL b2b_done_op%0d edge %0d got %b want %b",
                         o, k, done, j == el - 1);
            end
            if (j == el - 1) begin
                ref_model(o, sa, sb, ss, er, eh, ed, el);
                lr = er; lh = eh; ld = ed; have = 1;
                checks++;
                if ({res, hi, dbz} !== {er, eh, ed}) begin
                    errors++;
                    $display("FAIL b2b_result_op%0d got r=%h h=%h want r=%h h=%h",
                             o, res, hi, er, eh);
                end
            end else if (have) begin
                checks++;
                if ({res, hi, dbz} !== {lr, lh, ld}) begin
                    errors++;
                    $display("FAIL b2b_hold_op%0d got r=%h h=%h want r=%h h=%h",
                             o, res, hi, lr, lh);
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_multu();
        test_divu();
        test_random();
        test_reset_mid_op();
        test_back_to_back(4'd3, 6);
        test_back_to_back(4'd10, 2);
        test_back_to_back(4'd11, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
